// File: rtl/ff_pkg.sv
// Shared types for the Food Fight ADC sequencer: FSM state encoding and
// analog-stick channel codes.
package ff_pkg;

  typedef enum logic {
    ADC_IDLE = 1'b0,
    ADC_CONV = 1'b1
  } adc_state_t;

  typedef logic [1:0] adc_ch_t;

  localparam adc_ch_t ADC_CH_AX0 = 2'd0;
  localparam adc_ch_t ADC_CH_AY0 = 2'd1;
  localparam adc_ch_t ADC_CH_AX1 = 2'd2;
  localparam adc_ch_t ADC_CH_AY1 = 2'd3;

endpackage

// File: rtl/adc_sar_core.sv
// Successive-approximation register: holds the partial result and bit index,
// and resolves one bit per step against the held sample.
module adc_sar_core
  import ff_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [DW-1:0] sample_i,
  output logic [DW-1:0] sar_o,
  output logic [DW-1:0] sar_next_o,
  output logic          last_o
);

  localparam int BW = (DW > 1) ? $clog2(DW) : 1;

  logic [DW-1:0] sar_q, sar_d, trial;
  logic [BW-1:0] bit_q, bit_d;

  always_comb begin
    trial = sar_q | (DW'(1) << bit_q);
    sar_d = (trial <= sample_i) ? trial : sar_q;
    last_o = (bit_q == '0);
    // After the LSB the index parks at the MSB, ready for the next conversion.
    bit_d = last_o ? BW'(DW - 1) : bit_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sar_q <= '0;
      bit_q <= BW'(DW - 1);
    end else if (load_i) begin
      sar_q <= '0;
      bit_q <= BW'(DW - 1);
    end else if (step_i) begin
      sar_q <= sar_d;
      bit_q <= bit_d;
    end
  end

  assign sar_o      = sar_q;
  assign sar_next_o = sar_d;

endmodule

// File: rtl/ff_adc_sequencer.sv
// ADC0809-style 4-channel conversion sequencer: latches a channel sample on START,
// runs an 8-step SAR paced by CEN, then publishes DOUT with EOC/BUSY.
module ff_adc_sequencer
  import ff_pkg::*;
#(
  parameter int BIT_TICKS = 8,
  parameter int DW        = 8
) (
  input  logic          MCLK,
  input  logic          RESET_N,
  input  logic          CEN,
  input  logic          START,
  input  adc_ch_t       CHSEL,
  input  logic [DW-1:0] AIN0,
  input  logic [DW-1:0] AIN1,
  input  logic [DW-1:0] AIN2,
  input  logic [DW-1:0] AIN3,
  output logic [DW-1:0] DOUT,
  output logic          EOC,
  output logic          BUSY,
  output adc_state_t    DBG_STATE
);

  localparam int TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;

  adc_state_t    state_q;
  logic [TW-1:0] ticks_q;
  logic [DW-1:0] sample_q, dout_q, ain_sel;
  logic          eoc_q, busy_q;
  logic          tick_last, sar_step, sar_last;
  logic [DW-1:0] sar_val, sar_next;

  always_comb begin
    ain_sel = AIN0;
    case (CHSEL)
      ADC_CH_AX0: ain_sel = AIN0;
      ADC_CH_AY0: ain_sel = AIN1;
      ADC_CH_AX1: ain_sel = AIN2;
      ADC_CH_AY1: ain_sel = AIN3;
      default:    ain_sel = AIN0;
    endcase
  end

  assign tick_last = (ticks_q == TW'(BIT_TICKS - 1));
  // START always wins over a bit resolution, including the final one.
  assign sar_step  = (state_q == ADC_CONV) && CEN && tick_last && !START;

  adc_sar_core #(.DW(DW)) u_sar (
    .clk        (MCLK),
    .rst_n      (RESET_N),
    .load_i     (START),
    .step_i     (sar_step),
    .sample_i   (sample_q),
    .sar_o      (sar_val),
    .sar_next_o (sar_next),
    .last_o     (sar_last)
  );

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ADC_IDLE;
      ticks_q  <= '0;
      sample_q <= '0;
      dout_q   <= '0;
      eoc_q    <= 1'b1;
      busy_q   <= 1'b0;
    end else if (START) begin
      state_q  <= ADC_CONV;
      ticks_q  <= '0;
      sample_q <= ain_sel;
      eoc_q    <= 1'b0;
      busy_q   <= 1'b1;
    end else if (state_q == ADC_CONV && CEN) begin
      if (tick_last) begin
        ticks_q <= '0;
        if (sar_last) begin
          dout_q  <= sar_next;
          eoc_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ADC_IDLE;
        end
      end else begin
        ticks_q <= ticks_q + 1'b1;
      end
    end
  end

  assign DOUT      = dout_q;
  assign EOC       = eoc_q;
  assign BUSY      = busy_q;
  assign DBG_STATE = state_q;

endmodule
